// File: rtl/mul_ctrl_pkg.sv
// Shared constants and state encoding for the shared-multiplier controller.
package mul_ctrl_pkg;

    localparam int OP_W           = 32;  // operand width
    localparam int PROD_W         = 64;  // product width
    localparam int MUL_CYCLES_DEF = 33;  // 1 load edge + 32 shift-add iterations
    localparam int CNT_W          = 6;   // wide enough to hold MUL_CYCLES

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    // Two passes: indices >= ptr first, then any index (only reached when the upper
    // range was empty, so it picks the lowest set bit below ptr).
    always_comb begin
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (ID_W'(j) >= ptr)) begin
                grant[j] = 1'b1;
                grant_id = ID_W'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                grant_id = ID_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one sequential 32x32 multiplier among NUM_REQ requesters: round-robin
// grant, clear the multiplier, hold operands, count its latency, return the product.
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [PROD_W-1:0]       resp_product,
    input  logic                    resp_ready,
    output logic                    busy,
    output logic                    mul_reset,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [PROD_W-1:0]       mul_product
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                resp_valid_q, resp_valid_d;
    logic [PROD_W-1:0]   resp_product_q, resp_product_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grants are only offered from IDLE; suppressed while reset is applied.
    assign req_ready    = (state_q == ST_IDLE && !reset) ? grant : '0;
    assign busy         = (state_q != ST_IDLE);
    assign mul_reset    = reset | (state_q == ST_CLEAR);
    assign mul_a        = a_q;
    assign mul_b        = b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = id_q;
    assign resp_product = resp_product_q;

    // Next-state and datapath updates for the IDLE/CLEAR/RUN/DONE sequence.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        id_d           = id_q;
        resp_valid_d   = resp_valid_q;
        resp_product_d = resp_product_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            a_d = req_a[OP_W*i +: OP_W];
                            b_d = req_b[OP_W*i +: OP_W];
                        end
                    end
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_CYCLES)) begin
                    resp_product_d = mul_product;
                    resp_valid_d   = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            id_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_product_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            id_q           <= id_d;
            resp_valid_q   <= resp_valid_d;
            resp_product_q <= resp_product_d;
        end
    end

endmodule
